// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state numbers, opcodes,
// datapath select codes and the packed control word.
package mc_ctrl_pkg;

    localparam int unsigned S_FETCH    = 0;
    localparam int unsigned S_DECODE   = 1;
    localparam int unsigned S_MEMADR   = 2;
    localparam int unsigned S_MEMRD    = 3;
    localparam int unsigned S_MEMWB    = 4;
    localparam int unsigned S_MEMWR    = 5;
    localparam int unsigned S_EXEC     = 6;
    localparam int unsigned S_RTYPE_WB = 7;
    localparam int unsigned S_BRANCH   = 8;
    localparam int unsigned S_JUMP     = 9;
    localparam int unsigned S_ADDI_EX  = 10;
    localparam int unsigned S_ADDI_WB  = 11;
    localparam int unsigned S_ILLEGAL  = 12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_c;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word decode. mem_ok qualifies the side effects
// that must happen only once a wait-state memory access has completed.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic               mem_ok,
    output ctrl_t              ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            STATE_W'(S_FETCH): begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ok;
                ctrl.pc_write  = mem_ok;
            end
            STATE_W'(S_DECODE): begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            STATE_W'(S_MEMADR), STATE_W'(S_ADDI_EX): begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            STATE_W'(S_MEMRD): begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            STATE_W'(S_MEMWB): begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            // mem_write stays up for the whole dwell; the memory commits on mem_ready.
            STATE_W'(S_MEMWR): begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ok;
            end
            STATE_W'(S_EXEC): begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            STATE_W'(S_RTYPE_WB): begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            STATE_W'(S_BRANCH): begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_write_c = 1'b1;
                ctrl.pc_source  = PC_SRC_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            STATE_W'(S_JUMP): begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_SRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            STATE_W'(S_ADDI_WB): begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: state register, next-state logic, sticky halt on
// illegal opcodes and a wrapping retired-instruction counter.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4,
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_c,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                ir_write,
    output logic [1:0]          pc_source,
    output logic [1:0]          alu_op,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                instr_done,
    output logic                halted,
    output logic [STATE_W-1:0]  state,
    output logic [CNT_W-1:0]    retired
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               halted_q, halted_d;
    logic               is_sw_q, is_sw_d;
    logic               mem_ok;
    ctrl_t              ctrl_raw, ctrl;

    assign mem_ok = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    mc_ctrl_decode #(.STATE_W(STATE_W)) u_decode (
        .state  (state_q),
        .mem_ok (mem_ok),
        .ctrl   (ctrl_raw)
    );

    assign ctrl = rst_n ? ctrl_raw : '0;

    always_comb begin
        state_d   = state_q;
        is_sw_d   = is_sw_q;
        case (state_q)
            STATE_W'(S_FETCH):  state_d = mem_ok ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
            STATE_W'(S_DECODE): begin
                // The opcode is only trusted here; lw/sw is remembered for MEMADR.
                is_sw_d = (opcode == OPCODE_W'(OP_SW));
                if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW))
                    state_d = STATE_W'(S_MEMADR);
                else if (opcode == OPCODE_W'(OP_RTYPE))
                    state_d = STATE_W'(S_EXEC);
                else if (opcode == OPCODE_W'(OP_BEQ))
                    state_d = STATE_W'(S_BRANCH);
                else if (opcode == OPCODE_W'(OP_J))
                    state_d = STATE_W'(S_JUMP);
                else if (opcode == OPCODE_W'(OP_ADDI))
                    state_d = STATE_W'(S_ADDI_EX);
                else
                    state_d = STATE_W'(S_ILLEGAL);
            end
            STATE_W'(S_MEMADR):  state_d = is_sw_q ? STATE_W'(S_MEMWR) : STATE_W'(S_MEMRD);
            STATE_W'(S_MEMRD):   state_d = mem_ok ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMRD);
            STATE_W'(S_MEMWR):   state_d = mem_ok ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWR);
            STATE_W'(S_EXEC):    state_d = STATE_W'(S_RTYPE_WB);
            STATE_W'(S_ADDI_EX): state_d = STATE_W'(S_ADDI_WB);
            STATE_W'(S_MEMWB), STATE_W'(S_RTYPE_WB), STATE_W'(S_BRANCH),
            STATE_W'(S_JUMP), STATE_W'(S_ADDI_WB):
                state_d = STATE_W'(S_FETCH);
            default: state_d = STATE_W'(S_ILLEGAL);
        endcase
        halted_d  = halted_q | (state_d == STATE_W'(S_ILLEGAL));
        retired_d = ctrl_raw.instr_done ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= STATE_W'(S_FETCH);
            retired_q <= '0;
            halted_q  <= 1'b0;
            is_sw_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            is_sw_q   <= is_sw_d;
        end
    end

    assign pc_write   = ctrl.pc_write;
    assign pc_write_c = ctrl.pc_write_c;
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign ir_write   = ctrl.ir_write;
    assign pc_source  = ctrl.pc_source;
    assign alu_op     = ctrl.alu_op;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign instr_done = ctrl.instr_done;
    assign halted     = halted_q;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: an instruction-level reference model expands each instruction
// into its expected per-cycle states and control words; a CNT_W=2 copy checks counter wrap.
module tb_mc_ctrl_fsm;

    localparam int K_LW = 0, K_SW = 1, K_RT = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;

    logic       pc_write, pc_write_c, i_or_d, mem_read, mem_write, mem_to_reg, ir_write;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic       alu_src_a, reg_write, reg_dst, instr_done, halted;
    logic [3:0] state;
    logic [15:0] retired;

    logic       d2_pc_write, d2_pc_write_c, d2_i_or_d, d2_mem_read, d2_mem_write, d2_mem_to_reg;
    logic       d2_ir_write, d2_alu_src_a, d2_reg_write, d2_reg_dst, d2_instr_done, d2_halted;
    logic [1:0] d2_pc_source, d2_alu_op, d2_alu_src_b;
    logic [3:0] d2_state;
    logic [1:0] d2_retired;

    int   errors = 0;
    int   checks = 0;
    int   retired_m = 0;
    logic halted_m = 1'b0;

    mc_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_c(pc_write_c), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .ir_write(ir_write),
        .pc_source(pc_source), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .reg_dst(reg_dst), .instr_done(instr_done), .halted(halted),
        .state(state), .retired(retired)
    );

    mc_ctrl_fsm #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(d2_pc_write), .pc_write_c(d2_pc_write_c), .i_or_d(d2_i_or_d),
        .mem_read(d2_mem_read), .mem_write(d2_mem_write), .mem_to_reg(d2_mem_to_reg),
        .ir_write(d2_ir_write), .pc_source(d2_pc_source), .alu_op(d2_alu_op),
        .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b), .reg_write(d2_reg_write),
        .reg_dst(d2_reg_dst), .instr_done(d2_instr_done), .halted(d2_halted),
        .state(d2_state), .retired(d2_retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected control word for a state, straight from the state table.
    // Order: pcw pcwc iord mr mw m2r irw pcs[2] aop[2] srca srcb[2] rw rdst done
    function automatic logic [16:0] ctrl_for(input int st, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rdst, done;
        logic [1:0] pcs, aop, srcb;
        {pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rdst, done} = '0;
        {pcs, aop, srcb} = '0;
        case (st)
            0:  begin mr = 1; irw = rdy; pcw = rdy; srcb = 2'd1; end
            1:  srcb = 2'd3;
            2:  begin srca = 1; srcb = 2'd2; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mw = 1; iord = 1; done = rdy; end
            6:  begin srca = 1; aop = 2'd2; end
            7:  begin rw = 1; rdst = 1; done = 1; end
            8:  begin srca = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; done = 1; end
            9:  begin pcw = 1; pcs = 2'd2; done = 1; end
            10: begin srca = 1; srcb = 2'd2; end
            11: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, srca, srcb, rw, rdst, done};
    endfunction

    function automatic logic [16:0] obs_ctrl();
        return {pc_write, pc_write_c, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
                pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, instr_done};
    endfunction

    function automatic logic [16:0] obs_ctrl2();
        return {d2_pc_write, d2_pc_write_c, d2_i_or_d, d2_mem_read, d2_mem_write, d2_mem_to_reg,
                d2_ir_write, d2_pc_source, d2_alu_op, d2_alu_src_a, d2_alu_src_b, d2_reg_write,
                d2_reg_dst, d2_instr_done};
    endfunction

    // One clock cycle: drive inputs, check against the expected state, advance.
    task automatic step(input int st, input logic rdy, input logic [5:0] op, output logic done_seen);
        logic [16:0] exp_c;
        mem_ready = rdy;
        opcode    = op;
        #2;
        exp_c = ctrl_for(st, rdy);
        if (st == 12) halted_m = 1'b1;
        check("state", 32'(state), 32'(st));
        check("ctrl", 32'(obs_ctrl()), 32'(exp_c));
        check("halted", 32'(halted), 32'(halted_m));
        check("retired", 32'(retired), 32'(retired_m % 65536));
        check("state_w2", 32'(d2_state), 32'(st));
        check("ctrl_w2", 32'(obs_ctrl2()), 32'(exp_c));
        check("halted_w2", 32'(d2_halted), 32'(halted_m));
        check("retired_w2", 32'(d2_retired), 32'(retired_m % 4));
        done_seen = instr_done;
        if (exp_c[0]) retired_m++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'($urandom);
        opcode    = 6'($urandom);
        #2;
        check("rst_ctrl_pre", 32'(obs_ctrl()), 32'd0);
        @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_retired_w2", 32'(d2_retired), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_ctrl", 32'(obs_ctrl()), 32'd0);
        @(posedge clk);
        #1;
        check("rst_state2", 32'(state), 32'd0);
        rst_n     = 1'b1;
        retired_m = 0;
        halted_m  = 1'b0;
    endtask

    // Expand an instruction into its expected cycle list and run it; wf/wm are the
    // number of cycles mem_ready is held low in FETCH and in MEMRD/MEMWR.
    task automatic run_instr(input int kind, input int wf, input int wm);
        int         sts[$];
        logic       rdys[$];
        logic [5:0] op;
        int         lat_exp, first_done, n_done;
        logic       d;
        case (kind)
            K_LW:    begin op = 6'b100011; lat_exp = 5 + wf + wm; end
            K_SW:    begin op = 6'b101011; lat_exp = 4 + wf + wm; end
            K_RT:    begin op = 6'b000000; lat_exp = 4 + wf; end
            K_BEQ:   begin op = 6'b000100; lat_exp = 3 + wf; end
            K_J:     begin op = 6'b000010; lat_exp = 3 + wf; end
            default: begin op = 6'b001000; lat_exp = 4 + wf; end
        endcase
        repeat (wf) begin sts.push_back(0); rdys.push_back(1'b0); end
        sts.push_back(0); rdys.push_back(1'b1);
        sts.push_back(1); rdys.push_back(1'($urandom));
        case (kind)
            K_LW: begin
                sts.push_back(2); rdys.push_back(1'($urandom));
                repeat (wm) begin sts.push_back(3); rdys.push_back(1'b0); end
                sts.push_back(3); rdys.push_back(1'b1);
                sts.push_back(4); rdys.push_back(1'($urandom));
            end
            K_SW: begin
                sts.push_back(2); rdys.push_back(1'($urandom));
                repeat (wm) begin sts.push_back(5); rdys.push_back(1'b0); end
                sts.push_back(5); rdys.push_back(1'b1);
            end
            K_RT: begin
                sts.push_back(6); rdys.push_back(1'($urandom));
                sts.push_back(7); rdys.push_back(1'($urandom));
            end
            K_BEQ: begin sts.push_back(8); rdys.push_back(1'($urandom)); end
            K_J:   begin sts.push_back(9); rdys.push_back(1'($urandom)); end
            default: begin
                sts.push_back(10); rdys.push_back(1'($urandom));
                sts.push_back(11); rdys.push_back(1'($urandom));
            end
        endcase
        first_done = 0;
        n_done = 0;
        foreach (sts[i]) begin
            step(sts[i], rdys[i], (sts[i] == 1) ? op : 6'($urandom), d);
            if (d === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = i + 1;
            end
        end
        check("latency", 32'(first_done), 32'(lat_exp));
        check("done_pulses", 32'(n_done), 32'd1);
    endtask

    task automatic run_illegal(input logic [5:0] op);
        logic d;
        step(0, 1'b1, 6'($urandom), d);
        step(1, 1'($urandom), op, d);
        repeat (10) step(12, 1'($urandom), 6'($urandom), d);
    endtask

    initial begin
        logic       d;
        logic [5:0] bad_op;

        do_reset();
        run_instr(K_LW, 0, 0);
        check("lw_retired", 32'(retired), 32'd1);
        run_instr(K_SW, 0, 3);

        do_reset();
        run_instr(K_RT, 0, 0);
        run_instr(K_BEQ, 0, 0);
        run_instr(K_J, 0, 0);
        run_instr(K_ADDI, 0, 0);
        check("seq_retired", 32'(retired), 32'd4);

        do_reset();
        run_illegal(6'b111111);
        do_reset();
        check("halt_cleared", 32'(halted), 32'd0);
        do
            bad_op = 6'($urandom);
        while (bad_op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
        run_illegal(bad_op);

        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_instr(K_J, 0, 0);
            check("wrap_w2", 32'(d2_retired), 32'((k + 1) % 4));
        end

        run_instr(K_J, 0, 0);
        step(0, 1'b1, 6'($urandom), d);
        step(1, 1'($urandom), 6'b100011, d);
        step(2, 1'($urandom), 6'($urandom), d);
        step(3, 1'b0, 6'($urandom), d);
        do_reset();
        run_instr(K_LW, 1, 2);

        for (int n = 0; n < 40; n++)
            run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
